// File: rtl/tetris_pkg.sv
// Shared types and constants for the 2x2-piece falling-block game controller.
package tetris_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_FALL,
        ST_LOCK,
        ST_CLEAR,
        ST_SPAWN,
        ST_OVER
    } state_t;

    localparam int NUM_KEYS  = 4;
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

endpackage

// File: rtl/tetris_game_ctrl_if.sv
// Player/display side of the game controller: key levels and frame pulse in,
// board image, score and game-over flag out.
interface tetris_game_ctrl_if
    import tetris_pkg::*;
#(
    parameter int BOARD_W = 8,
    parameter int BOARD_H = 18
);
    logic [NUM_KEYS-1:0]        op_keys;
    logic                       draw_finish;
    logic [BOARD_W*BOARD_H-1:0] data_updated;
    logic [15:0]                score;
    logic                       game_over;

    modport master (
        output op_keys, draw_finish,
        input  data_updated, score, game_over
    );

    modport slave (
        input  op_keys, draw_finish,
        output data_updated, score, game_over
    );
endinterface

// File: rtl/tetris_key_edge.sv
// Rising-edge detector with sticky per-key event flags; the game FSM clears
// individual flags through consume when it acts on them.
module tetris_key_edge #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] keys,
    input  logic [WIDTH-1:0] consume,
    output logic [WIDTH-1:0] flags
);
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] flag_q;

    // Sample keys and accumulate edges; a new edge wins over a same-cycle consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            flag_q <= '0;
        end else begin
            prev_q <= keys;
            flag_q <= (flag_q & ~consume) | (keys & ~prev_q);
        end
    end

    assign flags = flag_q;
endmodule

// File: rtl/tetris_game_ctrl.sv
// Game controller: one 2x2 piece moving over a settled board, gravity on a
// frame counter, row clearing one row per cycle, registered board image.
module tetris_game_ctrl
    import tetris_pkg::*;
#(
    parameter int BOARD_W     = 8,
    parameter int BOARD_H     = 18,
    parameter int FALL_FRAMES = 30,
    parameter int SPAWN_X     = 3
) (
    input  logic              clk,
    input  logic              rst,
    tetris_game_ctrl_if.slave bus
);
    localparam int N  = BOARD_W * BOARD_H;
    localparam int XW = $clog2(BOARD_W);
    localparam int YW = $clog2(BOARD_H);
    localparam int CW = $clog2(FALL_FRAMES + 1);

    localparam logic [N-1:0] ROW_M   = {{(N-BOARD_W){1'b0}}, {BOARD_W{1'b1}}};
    localparam logic [N-1:0] PIECE_M = {{(N-BOARD_W-2){1'b0}}, 2'b11,
                                        {(BOARD_W-2){1'b0}}, 2'b11};

    // Piece cells placed with top-left corner at (x,y); caller keeps x,y in range.
    function automatic logic [N-1:0] piece_mask(input int x, input int y);
        return PIECE_M << (x + BOARD_W * y);
    endfunction

    function automatic logic collides(input logic [N-1:0] b, input int x, input int y);
        if (x < 0 || y < 0 || x > BOARD_W - 2 || y > BOARD_H - 2)
            return 1'b1;
        return |(b & piece_mask(x, y));
    endfunction

    function automatic logic row_full(input logic [N-1:0] b, input int r);
        return ((b >> (BOARD_W * r)) & ROW_M) == ROW_M;
    endfunction

    // Rows 0..r move down by one, row 0 becomes empty, rows below r untouched.
    function automatic logic [N-1:0] drop_rows(input logic [N-1:0] b, input int r);
        logic [N-1:0] lo;
        lo = ~({N{1'b1}} << (BOARD_W * (r + 1)));
        return (b & ~lo) | ((b << BOARD_W) & lo);
    endfunction

    state_t          state_q, state_d;
    logic [N-1:0]    board_q, board_d;
    logic [N-1:0]    du_q, du_d;
    logic [XW-1:0]   px_q, px_d;
    logic [YW-1:0]   py_q, py_d;
    logic [YW-1:0]   row_q, row_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     score_q, score_d;
    logic            pend_q, pend_d;
    logic [NUM_KEYS-1:0] key_flags, consume;

    int   px_i, py_i;
    logic frame_req, left_ok, right_ok, fall_due, down_blocked;
    logic cur_row_full, spawn_blocked, du_load;

    tetris_key_edge #(.WIDTH(NUM_KEYS)) u_keys (
        .clk     (clk),
        .rst     (rst),
        .keys    (bus.op_keys),
        .consume (consume),
        .flags   (key_flags)
    );

    assign px_i          = int'(px_q);
    assign py_i          = int'(py_q);
    assign frame_req     = bus.draw_finish | pend_q;
    assign left_ok       = key_flags[KEY_LEFT] & ~key_flags[KEY_RIGHT]
                           & ~collides(board_q, px_i - 1, py_i);
    assign right_ok      = key_flags[KEY_RIGHT] & ~key_flags[KEY_LEFT]
                           & ~collides(board_q, px_i + 1, py_i);
    assign fall_due      = key_flags[KEY_DOWN] | (int'(cnt_q) == FALL_FRAMES - 1);
    assign down_blocked  = collides(board_q, px_i, py_i + 1);
    assign cur_row_full  = row_full(board_q, int'(row_q));
    assign spawn_blocked = collides(board_q, SPAWN_X, 0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (frame_req) state_d = ST_MOVE;
            ST_MOVE:  state_d = ST_FALL;
            ST_FALL:  state_d = (fall_due && down_blocked) ? ST_LOCK : ST_IDLE;
            ST_LOCK:  state_d = ST_CLEAR;
            ST_CLEAR: if (!cur_row_full && row_q == '0) state_d = ST_SPAWN;
            ST_SPAWN: state_d = spawn_blocked ? ST_OVER : ST_IDLE;
            ST_OVER:  if (key_flags[KEY_UP]) state_d = ST_SPAWN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath updates and key-flag consumption driven by the current state.
    always_comb begin
        board_d = board_q;
        px_d    = px_q;
        py_d    = py_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        consume = '0;
        // A frame pulse outside IDLE is remembered once, except in OVER.
        pend_d  = pend_q | bus.draw_finish;
        case (state_q)
            ST_IDLE: begin
                consume[KEY_UP] = 1'b1;
                pend_d          = 1'b0;
            end
            ST_MOVE: begin
                consume[KEY_UP]    = 1'b1;
                consume[KEY_LEFT]  = 1'b1;
                consume[KEY_RIGHT] = 1'b1;
                if (left_ok)       px_d = px_q - 1'b1;
                else if (right_ok) px_d = px_q + 1'b1;
            end
            ST_FALL: begin
                consume[KEY_UP] = 1'b1;
                if (fall_due) begin
                    consume[KEY_DOWN] = 1'b1;
                    cnt_d             = '0;
                    if (!down_blocked) py_d = py_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOCK: begin
                board_d = board_q | piece_mask(px_i, py_i);
                row_d   = YW'(BOARD_H - 1);
            end
            ST_CLEAR: begin
                // Keep r after a clear: the row shifted into r may be full too.
                if (cur_row_full) begin
                    board_d = drop_rows(board_q, int'(row_q));
                    score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
                end else if (row_q != '0) begin
                    row_d = row_q - 1'b1;
                end
            end
            ST_SPAWN: begin
                px_d = XW'(SPAWN_X);
                py_d = '0;
            end
            ST_OVER: begin
                pend_d = 1'b0;
                if (key_flags[KEY_UP]) begin
                    board_d = '0;
                    score_d = '0;
                    cnt_d   = '0;
                    consume = '1;
                end
            end
            default: ;
        endcase
    end

    // The visible image only refreshes on arrival in IDLE or OVER.
    assign du_load = (state_d != state_q) && (state_d == ST_IDLE || state_d == ST_OVER);
    assign du_d    = board_d | piece_mask(int'(px_d), int'(py_d));

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            board_q <= '0;
            du_q    <= '0;
            px_q    <= XW'(SPAWN_X);
            py_q    <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            score_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            board_q <= board_d;
            px_q    <= px_d;
            py_q    <= py_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            pend_q  <= pend_d;
            if (du_load) du_q <= du_d;
        end
    end

    assign bus.data_updated = du_q;
    assign bus.score        = score_q;
    assign bus.game_over    = (state_q == ST_OVER);
endmodule
